// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX-operand forwarding selects plus load-use stall and branch flush control.
// Define HAZ_FORWARDING_EN to enable forwarding; without it hazards stall until the producer reaches WB.
module hazard_forward_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                ex_branch_taken,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                stall,
  output logic                flush_ifid,
  output logic                flush_idex,
  output logic [CNT_BITS-1:0] stall_count
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state, state_nx;
  logic [REG_BITS-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, ex_load, hazard, unused;
  function automatic logic writes(input logic rw, input logic [REG_BITS-1:0] rd, input logic [REG_BITS-1:0] r);
    return rw && rd == r && r != '0;
  endfunction
  assign ex_load = id_valid && !stall && !flush_idex;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd  <= '0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      mem_rd <= '0;
      mem_rw <= 1'b0;
      mem_mr <= 1'b0;
      wb_rd  <= '0;
      wb_rw  <= 1'b0;
    end else begin
      ex_rs1 <= ex_load ? id_rs1 : '0;
      ex_rs2 <= ex_load ? id_rs2 : '0;
      ex_rd  <= ex_load ? id_rd : '0;
      ex_rw  <= ex_load && id_regwrite;
      ex_mr  <= ex_load && id_memread;
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      mem_mr <= ex_mr;
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
    end
  end
`ifdef HAZ_FORWARDING_EN
  assign fwd_a_sel = writes(mem_rw, mem_rd, ex_rs1) ? 2'b10 : writes(wb_rw, wb_rd, ex_rs1) ? 2'b01 : 2'b00;
  assign fwd_b_sel = writes(mem_rw, mem_rd, ex_rs2) ? 2'b10 : writes(wb_rw, wb_rd, ex_rs2) ? 2'b01 : 2'b00;
  assign hazard = ex_mr && (writes(ex_rw, ex_rd, id_rs1) || writes(ex_rw, ex_rd, id_rs2));
  assign unused = mem_mr;
`else
  // WB never hazards: the register file writes before it reads
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
  assign hazard = writes(ex_rw, ex_rd, id_rs1) || writes(ex_rw, ex_rd, id_rs2) ||
                  writes(mem_rw, mem_rd, id_rs1) || writes(mem_rw, mem_rd, id_rs2);
  assign unused = ^{ex_rs1, ex_rs2, ex_mr, mem_mr, wb_rd, wb_rw};
`endif
  always_ff @(posedge clk) state <= reset ? RUN : state_nx;
  always_comb state_nx = (state == RUN) ? (stall ? STALL : RUN) : ((stall && !ex_branch_taken) ? STALL : RUN);
  always_comb begin
    stall      = id_valid && hazard && !ex_branch_taken;
    flush_ifid = ex_branch_taken;
    flush_idex = ex_branch_taken;
  end
  always_ff @(posedge clk) begin
    if (reset) stall_count <= '0;
    else if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed and random stimulus against a queue-based pipeline model with a scoreboard.
module tb_hazard_forward_ctrl;
  localparam int RB = 5;
  localparam int CB = 3;
  typedef struct packed {logic [RB-1:0] rs1, rs2, rd; logic rw, mr;} ins_t;
  typedef struct packed {logic chk; logic [1:0] fa, fb; logic st, fi, fe; logic [CB-1:0] cnt;} exp_t;
  logic clk = 1'b0, reset = 1'b1, id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, ex_branch_taken = 1'b0;
  logic [RB-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall, flush_ifid, flush_idex;
  logic [CB-1:0] stall_count;
  exp_t expq[$];
  ins_t hist[$];
  int mcnt = 0, checks = 0, passes = 0;
  bit last_stall = 0;
  hazard_forward_ctrl #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .stall_count(stall_count));
  always #5 clk = ~clk;
  function automatic bit wr(input ins_t s, input logic [RB-1:0] r);
    return s.rw && s.rd == r && r != 0;
  endfunction
  function automatic ins_t mk(input int rs1, input int rs2, input int rd, input bit rw, input bit mr);
    ins_t i;
    i.rs1 = RB'(rs1); i.rs2 = RB'(rs2); i.rd = RB'(rd); i.rw = rw; i.mr = mr;
    return i;
  endfunction
  function automatic logic [1:0] fsel(input ins_t mem, input ins_t wb, input logic [RB-1:0] r);
`ifdef HAZ_FORWARDING_EN
    return wr(mem, r) ? 2'b10 : wr(wb, r) ? 2'b01 : 2'b00;
`else
    return (mem.rw ^ mem.rw) ? r[1:0] : (wb.rw ^ wb.rw) ? 2'b11 : 2'b00;
`endif
  endfunction
  // one clock cycle: drive ID, predict outputs from the last three EX entrants, then advance the model
  task automatic step(input bit v, input ins_t i, input bit br, input bit rst);
    exp_t e;
    ins_t ex, mem, wb;
    bit hz;
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; ex_branch_taken = br;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr;
    ex = hist[0]; mem = hist[1]; wb = hist[2];
`ifdef HAZ_FORWARDING_EN
    hz = ex.mr && (wr(ex, i.rs1) || wr(ex, i.rs2));
`else
    hz = wr(ex, i.rs1) || wr(ex, i.rs2) || wr(mem, i.rs1) || wr(mem, i.rs2);
`endif
    e.chk = !rst;
    e.fa = fsel(mem, wb, ex.rs1);
    e.fb = fsel(mem, wb, ex.rs2);
    e.st = v && hz && !br;
    e.fi = br;
    e.fe = br;
    e.cnt = CB'(mcnt);
    expq.push_back(e);
    last_stall = e.st;
    if (rst) begin
      hist = '{'0, '0, '0};
      mcnt = 0;
    end else begin
      hist.push_front((v && !e.st && !br) ? i : '0);
      void'(hist.pop_back());
      if (e.st && mcnt < (1 << CB) - 1) mcnt++;
    end
  endtask
  // hold the instruction in ID while the model says it is stalled
  task automatic issue(input ins_t i, input bit br);
    int n = 0;
    do begin
      step(1, i, br, 0);
      n++;
    end while (last_stall && n < 4);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, 0);
  endtask
  task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.chk) begin
        cmp("fwd_a_sel", {2'b0, fwd_a_sel}, {2'b0, e.fa});
        cmp("fwd_b_sel", {2'b0, fwd_b_sel}, {2'b0, e.fb});
        cmp("stall", {3'b0, stall}, {3'b0, e.st});
        cmp("flush_ifid", {3'b0, flush_ifid}, {3'b0, e.fi});
        cmp("flush_idex", {3'b0, flush_idex}, {3'b0, e.fe});
        cmp("stall_count", {1'b0, stall_count}, {1'b0, e.cnt});
      end
    end
  end
  initial begin
    hist = '{'0, '0, '0};
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    idle(5);
    issue(mk(1, 2, 5, 1, 0), 0);
    issue(mk(5, 3, 6, 1, 0), 0);
    idle(4);
    issue(mk(1, 2, 5, 1, 0), 0);
    issue(mk(8, 9, 10, 1, 0), 0);
    issue(mk(5, 3, 6, 1, 0), 0);
    idle(4);
    issue(mk(1, 2, 5, 1, 0), 0);
    issue(mk(3, 4, 5, 1, 0), 0);
    issue(mk(6, 5, 7, 1, 0), 0);
    idle(4);
    issue(mk(2, 0, 7, 1, 1), 0);
    issue(mk(7, 1, 8, 1, 0), 0);
    idle(4);
    issue(mk(2, 0, 0, 1, 1), 0);
    issue(mk(0, 1, 8, 1, 0), 0);
    idle(4);
    issue(mk(2, 0, 7, 1, 1), 0);
    issue(mk(7, 1, 8, 1, 0), 1);
    idle(4);
    for (int k = 0; k < 5; k++) begin
      issue(mk(1, 2, 3, 1, 1), 0);
      issue(mk(3, 3, 4, 1, 0), 0);
    end
    idle(3);
    issue(mk(1, 2, 3, 1, 1), 0);
    step(1, mk(3, 0, 4, 1, 0), 0, 0);
    step(0, '0, 0, 1);
    idle(3);
    for (int k = 0; k < 400; k++)
      step($urandom_range(3) != 0,
           mk($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(1) == 1, $urandom_range(1) == 1),
           $urandom_range(7) == 0, $urandom_range(63) == 0);
    idle(3);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
